multicycle_datapath: RTL and testbench

- Datapath half of the multicycle ARM core; consumes every control strobe produced by `control_unit` each cycle.
- Returns the instruction fields (`Cond`, `Op`, `Funct`, `Rd`) and ALU flags that `control_unit` decodes.
- Holds the architectural state: PC, IR, register file R0–R14, and the non-architectural latches (Data, A, WriteData, ALUOut).
- Talks to a unified instruction/data memory through `Adr`/`WriteData`/`ReadData`; memory write-enable comes straight from `control_unit`.

---
 rtl/multicycle_datapath_pkg.sv | 27 ++
 rtl/multicycle_regfile.sv | 39 +++
 rtl/multicycle_datapath.sv | 148 ++++++++++++++
 tb/tb_multicycle_datapath.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multicycle ARM datapath and its control unit.
// The control unit imports this same package, so both sides use one set of codes:
//   ALU operations, Result mux selects, ALU B-operand selects,
//   immediate formats, and the R15 register index.
package multicycle_datapath_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8    = 2'b00;
  localparam logic [1:0] IMM_12   = 2'b01;
  localparam logic [1:0] IMM_BR   = 2'b10;
  localparam logic [1:0] IMM_ZERO = 2'b11;

  localparam logic [3:0] R15_IDX = 4'd15;

endpackage

// File: rtl/multicycle_regfile.sv
// Register file R0-R14 for the multicycle datapath.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears R0-R14)
//   we, wa, wd    : synchronous write port; writes addressed to R15 are dropped
//   ra1, ra2      : combinational read addresses
//   r15           : value returned when a read addresses R15
//   rd1, rd2      : combinational read data (old value on same-cycle write)
module multicycle_regfile
  import multicycle_datapath_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [3:0]    ra1,
  input  logic [3:0]    ra2,
  input  logic [DW-1:0] r15,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);

  logic [DW-1:0] regs [15];

  // R15 is not stored here: the PC path owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else if (we && (wa != R15_IDX)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == R15_IDX) ? r15 : regs[ra1];
  assign rd2 = (ra2 == R15_IDX) ? r15 : regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Datapath half of the multicycle ARM core. Holds PC, IR, R0-R14 and the
// non-architectural latches (Data, A, WriteData, ALUOut); all sequencing
// comes from the control unit through the strobes below.
// Optional build macro: ROTATE_IMM_EN -- ImmSrc=00 produces the ARM rotated
// immediate (IR[7:0] rotated right by 2*IR[11:8]) instead of a zero-extend.
// Ports:
//   clk, Reset          : clock, asynchronous active-high reset
//   PCWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegSrc, ALUCtrl : control strobes from the control unit
//   ReadData            : memory read data
//   Adr, WriteData      : memory address and store data (B latch)
//   Cond, Op, Funct, Rd : instruction fields for decode
//   ALUFlags            : {N,Z,C,V} of the current ALU result (combinational)
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          PCWrite,
  input  logic          RegWrite,
  input  logic          IRWrite,
  input  logic          AdrSrc,
  input  logic [1:0]    ResultSrc,
  input  logic          ALUSrcA,
  input  logic [1:0]    ALUSrcB,
  input  logic [1:0]    ImmSrc,
  input  logic [1:0]    RegSrc,
  input  logic [1:0]    ALUCtrl,
  input  logic [DW-1:0] ReadData,
  output logic [DW-1:0] Adr,
  output logic [DW-1:0] WriteData,
  output logic [3:0]    Cond,
  output logic [1:0]    Op,
  output logic [5:0]    Funct,
  output logic [3:0]    Rd,
  output logic [3:0]    ALUFlags
);

  logic [DW-1:0] pc, ir, data, a, alu_out;
  logic [DW-1:0] rd1, rd2, ext_imm, src_a, src_b, b_eff, alu_result, result;
  logic [DW:0]   sum;
  logic [3:0]    ra1, ra2;
  logic          arith;

  function automatic logic [DW-1:0] extend(input logic [23:0] imm, input logic [1:0] src);
    logic [DW-1:0] imm8;
`ifdef ROTATE_IMM_EN
    logic [2*DW-1:0] dbl;
`endif
    imm8 = {{(DW-8){1'b0}}, imm[7:0]};
    case (src)
      IMM_8: begin
`ifdef ROTATE_IMM_EN
        // Rotate right by shifting a doubled copy; the low half is the result.
        dbl    = {imm8, imm8} >> {imm[11:8], 1'b0};
        extend = dbl[DW-1:0];
`else
        extend = imm8;
`endif
      end
      IMM_12:  extend = {{(DW-12){1'b0}}, imm[11:0]};
      IMM_BR:  extend = {{(DW-26){imm[23]}}, imm[23:0], 2'b00};
      default: extend = '0;
    endcase
  endfunction

  assign Cond  = ir[31:28];
  assign Op    = ir[27:26];
  assign Funct = ir[25:20];
  assign Rd    = ir[15:12];

  assign ra1 = RegSrc[0] ? R15_IDX : ir[19:16];
  assign ra2 = RegSrc[1] ? ir[15:12] : ir[3:0];

  multicycle_regfile #(.DW(DW)) u_regfile (
    .clk (clk),
    .rst (Reset),
    .we  (RegWrite),
    .wa  (ir[15:12]),
    .wd  (result),
    .ra1 (ra1),
    .ra2 (ra2),
    .r15 (result),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign ext_imm = extend(ir[23:0], ImmSrc);
  assign src_a   = ALUSrcA ? pc : a;

  always_comb begin
    case (ALUSrcB)
      SRCB_WD:   src_b = WriteData;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = DW'(4);
      default:   src_b = '0;
    endcase
  end

  // SUB is SrcA + ~SrcB + 1, so carry-out is NOT borrow.
  always_comb begin
    arith = (ALUCtrl == ALU_ADD) || (ALUCtrl == ALU_SUB);
    b_eff = (ALUCtrl == ALU_SUB) ? ~src_b : src_b;
    sum   = {1'b0, src_a} + {1'b0, b_eff} + {{DW{1'b0}}, (ALUCtrl == ALU_SUB)};
    case (ALUCtrl)
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: alu_result = sum[DW-1:0];
    endcase
    ALUFlags[3] = alu_result[DW-1];
    ALUFlags[2] = (alu_result == '0);
    ALUFlags[1] = arith & sum[DW];
    ALUFlags[0] = arith & (src_a[DW-1] == b_eff[DW-1]) & (sum[DW-1] != src_a[DW-1]);
  end

  always_comb begin
    case (ResultSrc)
      RES_DATA:      result = data;
      RES_ALURESULT: result = alu_result;
      default:       result = alu_out;
    endcase
  end

  assign Adr = AdrSrc ? result : pc;

  // Step boundary: every latch below is the hand-off to the next cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc        <= PC_RESET;
      ir        <= '0;
      data      <= '0;
      a         <= '0;
      WriteData <= '0;
      alu_out   <= '0;
    end else begin
      data      <= ReadData;
      a         <= rd1;
      WriteData <= rd2;
      alu_out   <= alu_result;
      if (IRWrite) ir <= ReadData;
      if (PCWrite) pc <= result;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

  logic        clk;
  logic        Reset;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUCtrl;
  logic [31:0] ReadData, Adr, WriteData;
  logic [3:0]  Cond, Rd, ALUFlags;
  logic [1:0]  Op;
  logic [5:0]  Funct;

  multicycle_datapath #(.DW(32), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .Reset(Reset), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUCtrl(ALUCtrl), .ReadData(ReadData), .Adr(Adr), .WriteData(WriteData),
    .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  typedef struct {
    logic [31:0] a_val;
    logic [11:0] imm;
    logic [1:0]  ctrl;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
  } alu_vec_t;

  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [31:0] v);
    sb.push_back('{name, v});
  endtask

  task automatic check(input logic [31:0] actual);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", actual);
    end else begin
      it = sb.pop_front();
      if (actual !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, actual, it.exp);
      end
    end
  endtask

  task automatic idle();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; ALUSrcA = 0;
    ResultSrc = 2'b00; ALUSrcB = 2'b00; ImmSrc = 2'b00; RegSrc = 2'b00;
    ALUCtrl = 2'b00;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    idle();
    ReadData = instr;
    IRWrite  = 1;
    tick();
    IRWrite  = 0;
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
    load_ir({20'hE0000, idx, 12'h000});
    ReadData = val;
    tick();
    ResultSrc = 2'b01;
    RegWrite  = 1;
    tick();
    idle();
  endtask

  task automatic read_reg(input logic [3:0] idx, input string name, input logic [31:0] exp);
    load_ir({28'hE000000, idx});
    tick();
    expect_val(name, exp);
    check(WriteData);
  endtask

  task automatic set_pc(input logic [31:0] val);
    idle();
    ReadData = val;
    tick();
    ResultSrc = 2'b01;
    PCWrite   = 1;
    tick();
    idle();
  endtask

  alu_vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h7FFF_FFFF, 12'h001, 2'b00, 32'h8000_0000, 4'b1001};
    vecs[1] = '{32'h0000_0005, 12'h005, 2'b01, 32'h0000_0000, 4'b0110};
    vecs[2] = '{32'h0000_0000, 12'h000, 2'b11, 32'h0000_0000, 4'b0100};
    vecs[3] = '{32'hFFFF_FFFF, 12'h001, 2'b00, 32'h0000_0000, 4'b0110};
    vecs[4] = '{32'h8000_0000, 12'h001, 2'b01, 32'h7FFF_FFFF, 4'b0011};
    vecs[5] = '{32'h0000_0003, 12'h005, 2'b01, 32'hFFFF_FFFE, 4'b1000};
    vecs[6] = '{32'hF0F0_F0F0, 12'h0FF, 2'b10, 32'h0000_00F0, 4'b0000};
    vecs[7] = '{32'h8000_0000, 12'h001, 2'b11, 32'h8000_0001, 4'b1000};
    vecs[8] = '{32'h0000_0FFF, 12'hFFF, 2'b00, 32'h0000_1FFE, 4'b0000};

    idle();
    ReadData = 32'h0;
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    #1;
    expect_val("reset_adr", 32'h0);      check(Adr);
    expect_val("reset_cond", 32'h0);     check({28'h0, Cond});
    expect_val("reset_op", 32'h0);       check({30'h0, Op});
    expect_val("reset_funct", 32'h0);    check({26'h0, Funct});
    expect_val("reset_rd", 32'h0);       check({28'h0, Rd});
    expect_val("reset_wdata", 32'h0);    check(WriteData);

    // Fetch: IR <- ReadData, PC <- PC + 4.
    ReadData = 32'hE3A0_5007;
    IRWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ALUCtrl = 2'b00;
    ResultSrc = 2'b10; PCWrite = 1;
    tick();
    idle();
    #1;
    expect_val("fetch_adr", 32'h4);       check(Adr);
    expect_val("fetch_cond", 32'hE);      check({28'h0, Cond});
    expect_val("fetch_op", 32'h0);        check({30'h0, Op});
    expect_val("fetch_funct", 32'h3A);    check({26'h0, Funct});
    expect_val("fetch_rd", 32'h5);        check({28'h0, Rd});

    // ALU vectors: SrcA = PC, SrcB = 12-bit immediate from IR.
    for (int i = 0; i < 9; i++) begin
      load_ir({20'hE0000, vecs[i].imm});
      set_pc(vecs[i].a_val);
      ALUSrcA = 1; ALUSrcB = 2'b01; ImmSrc = 2'b01; ALUCtrl = vecs[i].ctrl;
      ResultSrc = 2'b10; AdrSrc = 1;
      #1;
      expect_val($sformatf("alu_result_%0d", i), vecs[i].exp_res);
      check(Adr);
      expect_val($sformatf("alu_flags_%0d", i), {28'h0, vecs[i].exp_flags});
      check({28'h0, ALUFlags});
      idle();
    end

    // LDR R2, [R1, #4]
    write_reg(4'd1, 32'h100);
    load_ir(32'hE591_2004);
    tick();
    ALUSrcA = 0; ALUSrcB = 2'b01; ImmSrc = 2'b01; ALUCtrl = 2'b00; ResultSrc = 2'b10;
    tick();
    AdrSrc = 1; ResultSrc = 2'b00;
    #1;
    expect_val("ldr_adr", 32'h104);       check(Adr);
    ReadData = 32'h0000_DEAD;
    tick();
    AdrSrc = 0; ResultSrc = 2'b01; RegWrite = 1;
    tick();
    idle();
    read_reg(4'd2, "ldr_r2", 32'h0000_DEAD);

    // STR R3, [R1, #8]
    write_reg(4'd3, 32'h0000_CAFE);
    load_ir(32'hE581_3008);
    RegSrc = 2'b10;
    tick();
    expect_val("str_wdata", 32'h0000_CAFE); check(WriteData);
    ALUSrcA = 0; ALUSrcB = 2'b01; ImmSrc = 2'b01; ALUCtrl = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1;
    #1;
    expect_val("str_adr", 32'h108);       check(Adr);
    idle();

    // Branch with offset -8: target equals the fetch address.
    set_pc(32'h40);
    ReadData = 32'hEAFF_FFFE;
    IRWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1;
    tick();
    idle();
    RegSrc = 2'b01; ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    tick();
    idle();
    ALUSrcA = 0; ALUSrcB = 2'b01; ImmSrc = 2'b10; ALUCtrl = 2'b00;
    ResultSrc = 2'b10; AdrSrc = 1;
    #1;
    expect_val("branch_target", 32'h40);  check(Adr);
    AdrSrc = 0; PCWrite = 1;
    tick();
    idle();
    #1;
    expect_val("branch_pc", 32'h40);      check(Adr);

    // RegWrite to Rd=15 must not disturb the register file or the PC.
    load_ir(32'hE000_F000);
    ReadData = 32'h5555_5555;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    idle();
    #1;
    expect_val("r15_write_pc", 32'h40);   check(Adr);
    read_reg(4'd1, "r15_write_r1", 32'h100);
    read_reg(4'd2, "r15_write_r2", 32'h0000_DEAD);
    read_reg(4'd3, "r15_write_r3", 32'h0000_CAFE);

    // Reset arrives between decode and write-back of R4.
    load_ir(32'hE000_4000);
    ReadData = 32'h0000_1234;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    #2;
    Reset = 1;
    #1;
    expect_val("async_reset_adr", 32'h0);  check(Adr);
    expect_val("async_reset_rd", 32'h0);   check({28'h0, Rd});
    tick();
    Reset = 0;
    idle();
    read_reg(4'd1, "midop_r1", 32'h0);
    read_reg(4'd2, "midop_r2", 32'h0);
    read_reg(4'd3, "midop_r3", 32'h0);
    read_reg(4'd4, "midop_r4", 32'h0);
    idle();
    #1;
    expect_val("midop_pc", 32'h0);        check(Adr);

    // Immediate formats with IR[23:0] = 0x0004FF and PC = 0.
    load_ir(32'hE000_04FF);
    ALUSrcA = 1; ALUSrcB = 2'b01; ALUCtrl = 2'b00; ResultSrc = 2'b10; AdrSrc = 1;
    ImmSrc = 2'b00;
    #1;
`ifdef ROTATE_IMM_EN
    expect_val("imm8_rot", 32'hFF00_0000);
`else
    expect_val("imm8_zext", 32'h0000_00FF);
`endif
    check(Adr);
    ImmSrc = 2'b01;
    #1;
    expect_val("imm12", 32'h0000_04FF);   check(Adr);
    ImmSrc = 2'b10;
    #1;
    expect_val("imm_branch", 32'h0000_13FC); check(Adr);
    ImmSrc = 2'b11;
    #1;
    expect_val("imm_zero", 32'h0);        check(Adr);
    idle();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
